// File: rtl/nim_tac_pulser.sv
// NIM start/stop pulse-pair generator for TAC calibration.
// A trigger edge launches a burst of start/stop pulse pairs with programmable width, delay and period.
module nim_tac_pulser #(
   parameter int unsigned CNT_W = 32,
   parameter int unsigned NOUT  = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             trigger,
   input  logic [1:0]       start_sel,
   input  logic [1:0]       stop_sel,
   input  logic [7:0]       pulse_width,
   input  logic [CNT_W-1:0] delay,
   input  logic [CNT_W-1:0] period,
   input  logic [15:0]      burst_count,
   output logic [NOUT-1:0]  outputs,
   output logic             busy,
   output logic             done,
   output logic [15:0]      pairs_sent
);

   localparam int unsigned TW = CNT_W + 1;

   typedef enum logic [0:0] {StIdle, StActive} state_e;

   state_e           state_q, state_d;
   logic             trig_q, trig_z;
   logic [1:0]       samp_vld_q;
   logic [7:0]       w_q, w_d;
   logic [CNT_W-1:0] d_q, d_d;
   logic [TW-1:0]    pe_q, pe_d;
   logic [15:0]      burst_q, burst_d;
   logic [1:0]       start_sel_q, start_sel_d;
   logic [1:0]       stop_sel_q, stop_sel_d;
   logic [TW-1:0]    t_q, t_d;
   logic [15:0]      pairs_q, pairs_d;
   logic             done_q, done_d;
   logic [NOUT-1:0]  out_q, out_d;

   logic [7:0]       w_in;
   logic [TW-1:0]    dw_in;
   logic [TW-1:0]    pe_in;
   logic             launch;
   logic             start_hit;
   logic             stop_hit;

   // Effective width and period from the live inputs; only used at the launch edge.
   always_comb begin
      w_in  = (pulse_width == 8'd0) ? 8'd1 : pulse_width;
      dw_in = {1'b0, delay} + TW'(w_in);
      pe_in = {1'b0, period};
      if (dw_in > pe_in) begin
         pe_in = dw_in;
      end
      if (pe_in == '0) begin
         pe_in = TW'(1);
      end
   end

   // trig_z is only a real sample two clocks after reset, so a held trigger cannot launch.
   assign launch = (state_q == StIdle) && enable && trig_q && !trig_z && samp_vld_q[1];

   always_comb begin
      state_d     = state_q;
      t_d         = t_q;
      pairs_d     = pairs_q;
      done_d      = 1'b0;
      w_d         = w_q;
      d_d         = d_q;
      pe_d        = pe_q;
      burst_d     = burst_q;
      start_sel_d = start_sel_q;
      stop_sel_d  = stop_sel_q;

      unique case (state_q)
         StIdle: begin
            if (launch) begin
               state_d     = StActive;
               t_d         = '0;
               pairs_d     = '0;
               w_d         = w_in;
               d_d         = delay;
               pe_d        = pe_in;
               burst_d     = burst_count;
               start_sel_d = start_sel;
               stop_sel_d  = stop_sel;
            end
         end
         StActive: begin
            if (!enable) begin
               state_d = StIdle;
               t_d     = '0;
            end else if (t_q == pe_q - TW'(1)) begin
               t_d     = '0;
               pairs_d = (pairs_q == 16'hFFFF) ? pairs_q : pairs_q + 16'd1;
               if ((burst_q != 16'd0) && (pairs_d == burst_q)) begin
                  state_d = StIdle;
                  done_d  = 1'b1;
               end
            end else begin
               t_d = t_q + TW'(1);
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Outputs are decoded from next-state values so the pulse lines come straight from flops.
   always_comb begin
      start_hit = (state_d == StActive) && (t_d < TW'(w_d));
      stop_hit  = (state_d == StActive) && ({1'b0, d_d} <= t_d) &&
                  (t_d < ({1'b0, d_d} + TW'(w_d)));
      out_d = '0;
      for (int unsigned i = 0; i < NOUT; i++) begin
         out_d[i] = (start_hit && (32'(start_sel_d) == i)) ||
                    (stop_hit && (32'(stop_sel_d) == i));
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= StIdle;
         trig_q      <= 1'b0;
         trig_z      <= 1'b0;
         samp_vld_q  <= 2'b00;
         w_q         <= 8'd1;
         d_q         <= '0;
         pe_q        <= TW'(1);
         burst_q     <= '0;
         start_sel_q <= '0;
         stop_sel_q  <= '0;
         t_q         <= '0;
         pairs_q     <= '0;
         done_q      <= 1'b0;
         out_q       <= '0;
      end else begin
         state_q     <= state_d;
         trig_q      <= trigger;
         trig_z      <= trig_q;
         samp_vld_q  <= {samp_vld_q[0], 1'b1};
         w_q         <= w_d;
         d_q         <= d_d;
         pe_q        <= pe_d;
         burst_q     <= burst_d;
         start_sel_q <= start_sel_d;
         stop_sel_q  <= stop_sel_d;
         t_q         <= t_d;
         pairs_q     <= pairs_d;
         done_q      <= done_d;
         out_q       <= out_d;
      end
   end

   assign outputs    = out_q;
   assign busy       = (state_q == StActive);
   assign done       = done_q;
   assign pairs_sent = pairs_q;

endmodule

// File: doc/nim_tac_pulser.md
NIM_TAC_PULSER -- requirements
Module: nim_tac_pulser

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of delay/period counters.
REQ-002 SHALL have parameter NOUT, default 4, number of NIM output lines.
REQ-003 SHALL have port clk  input  1  single clock for all logic.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port enable  input  1  arms block; low aborts an active burst.
REQ-006 SHALL have port trigger  input  1  rising edge launches a burst.
REQ-007 SHALL have port start_sel  input  2  index of output line carrying the start pulse.
REQ-008 SHALL have port stop_sel  input  2  index of output line carrying the stop pulse.
REQ-009 SHALL have port pulse_width  input  8  pulse high time in cycles (W).
REQ-010 SHALL have port delay  input  CNT_W  start-rise to stop-rise in cycles (D).
REQ-011 SHALL have port period  input  CNT_W  start-rise to next start-rise in cycles (P).
REQ-012 SHALL have port burst_count  input  16  pulse pairs per burst; 0 = continuous.
REQ-013 SHALL have port outputs  output  NOUT  NIM pulse lines.
REQ-014 SHALL have port busy  output  1  high while in ACTIVE.
REQ-015 SHALL have port done  output  1  one-cycle strobe when a burst completes normally.
REQ-016 SHALL have port pairs_sent  output  16  completed pairs in current/last burst.

Function
REQ-017 SHALL register trigger twice (trig_q, trig_z); launch edge = clock edge where trig_q=1, trig_z=0, enable=1, state=IDLE.
REQ-018 SHALL implement states IDLE and ACTIVE; IDLE->ACTIVE on launch edge; ACTIVE->IDLE on burst end or abort.
REQ-019 SHALL latch W, D, P, burst_count, start_sel, stop_sel at launch edge; input changes during ACTIVE have no effect.
REQ-020 SHALL treat W=0 as W=1.
REQ-021 SHALL compute effective period Pe = max(P, D+W, 1) in CNT_W+1 bits, no truncation.
REQ-022 SHALL run in-pair cycle counter t: 0 in first cycle after launch edge, +1 per cycle, 0 again after t=Pe-1.
REQ-023 SHALL drive outputs[start_sel] high exactly when ACTIVE and t<W, registered, i.e. first high in cycle after launch edge.
REQ-024 SHALL drive outputs[stop_sel] high exactly when ACTIVE and D<=t<D+W.
REQ-025 SHALL OR both pulses onto one line when start_sel==stop_sel; unselected lines stay 0.
REQ-026 SHALL increment pairs_sent at each t=Pe-1 cycle, saturating at 0xFFFF; cleared to 0 on launch edge.
REQ-027 SHALL, when burst_count!=0 and completed pairs reach burst_count, go IDLE and pulse done for one cycle coincident with first IDLE cycle.
REQ-028 SHALL never end a continuous burst (burst_count=0) except by abort.
REQ-029 SHALL ignore trigger edges while ACTIVE (no restart, no queueing).
REQ-030 SHALL abort when enable=0 in ACTIVE: next cycle IDLE, all outputs 0, done stays 0, pairs_sent holds.
REQ-031 SHALL allow D=0 (stop coincident with start).

Reset
REQ-032 SHALL on reset assertion immediately force state IDLE, outputs=0, busy=0, done=0, pairs_sent=0, t=0, trig_q=trig_z=0.
REQ-033 SHALL on reset mid-burst truncate any pulse with no glitch beyond reset assertion and no done.
REQ-034 SHALL require a fresh trigger rising edge after reset release; trigger held high through reset launches nothing.

Verification
REQ-035 Single pair: W=4, D=10, P=20, burst=1, sel 0/1, trigger edge -> out[0] high 4 cycles, out[1] high 4 cycles starting 10 after out[0] rise, done once, pairs_sent=1.
REQ-036 Clamp: W=0, D=5, P=2, burst=3 -> W=1, Pe=6, three start pulses 6 cycles apart, done after third pair.
REQ-037 Shared line: start_sel=stop_sel=2, W=3, D=0 -> out[2] high 3 cycles per pair only.
REQ-038 Continuous + abort: burst=0, enable dropped mid-pulse -> outputs 0 next cycle, busy=0, done=0, pairs_sent holds.
REQ-039 Retrigger/config change during ACTIVE -> no timing change; pairs_sent reaches burst_count unchanged.
REQ-040 Async reset during stop pulse -> outputs 0 without clock edge; trigger held high after release launches nothing until a new edge.
